// File: rtl/cast_pipe_if.sv
// Handshake bundle for cast_pipe: upstream lhs/op channel plus downstream ret channel.
// The ovf wire exists only when CAST_PIPE_OVF_FLAG_EN is defined.
interface cast_pipe_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           op;
  logic [IN_WIDTH-1:0]  lhs;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] ret;
`ifdef CAST_PIPE_OVF_FLAG_EN
  logic                 ovf;
`endif

  modport master (
    output in_valid, op, lhs, out_ready,
    input  in_ready, out_valid, ret
`ifdef CAST_PIPE_OVF_FLAG_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, op, lhs, out_ready,
    output in_ready, out_valid, ret
`ifdef CAST_PIPE_OVF_FLAG_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/cast_pipe.sv
// Pipelined valid/ready integer cast (ZEXT/SEXT/TRUNC/SAT_TRUNC) with bubble-collapsing stages.
// Optional overflow flag output enabled by defining CAST_PIPE_OVF_FLAG_EN.
module cast_pipe #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 32,
  parameter int STAGES    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  cast_pipe_if.slave io
);
  localparam int N = IN_WIDTH;
  localparam int M = OUT_WIDTH;
  localparam logic [M-1:0] SMIN = M'(1) << (M-1);
  localparam logic [M-1:0] SMAX = ~SMIN;

  typedef enum logic [1:0] {OP_ZEXT, OP_SEXT, OP_TRUNC, OP_SAT} op_e;

  logic [M-1:0] zext_w, sext_w, sat_w, cast_ret;
`ifdef CAST_PIPE_OVF_FLAG_EN
  logic         lossy_u, lossy_s, cast_ovf;
`endif

  assign zext_w = M'(io.lhs);
  assign sext_w = M'($signed(io.lhs));

  if (M >= N) begin : g_wide
    assign sat_w = sext_w;
`ifdef CAST_PIPE_OVF_FLAG_EN
    assign lossy_u = 1'b0;
    assign lossy_s = 1'b0;
`endif
  end else begin : g_narrow
    // lhs fits a signed M-bit value iff bits [N-1:M-1] are all equal
    logic [N-M:0] top;
    logic         fits;
    assign top   = io.lhs[N-1:M-1];
    assign fits  = (&top) | ~(|top);
    assign sat_w = fits ? io.lhs[M-1:0] : (io.lhs[N-1] ? SMIN : SMAX);
`ifdef CAST_PIPE_OVF_FLAG_EN
    assign lossy_u = |io.lhs[N-1:M];
    assign lossy_s = ~fits;
`endif
  end

  always_comb begin
    cast_ret = zext_w;
`ifdef CAST_PIPE_OVF_FLAG_EN
    cast_ovf = 1'b0;
`endif
    case (op_e'(io.op))
      OP_ZEXT:  cast_ret = zext_w;
      OP_SEXT:  cast_ret = sext_w;
      OP_TRUNC: cast_ret = zext_w;
      OP_SAT:   cast_ret = sat_w;
      default:  cast_ret = zext_w;
    endcase
`ifdef CAST_PIPE_OVF_FLAG_EN
    cast_ovf = io.op[1] ? lossy_s : lossy_u;
`endif
  end

  logic [STAGES-1:0]        vld_q, vld_d, load;
  logic [STAGES-1:0][M-1:0] ret_q, ret_d;
`ifdef CAST_PIPE_OVF_FLAG_EN
  logic [STAGES-1:0]        ovf_q, ovf_d;
`endif

  // A stage may load unless it and every stage after it hold data while the consumer stalls.
  for (genvar k = 0; k < STAGES; k++) begin : g_load
    assign load[k] = enable & (io.out_ready | ~(&vld_q[STAGES-1:k]));
  end

  always_comb begin
    vld_d = vld_q;
    ret_d = ret_q;
`ifdef CAST_PIPE_OVF_FLAG_EN
    ovf_d = ovf_q;
`endif
    if (load[0]) begin
      vld_d[0] = io.in_valid;
      ret_d[0] = cast_ret;
`ifdef CAST_PIPE_OVF_FLAG_EN
      ovf_d[0] = cast_ovf;
`endif
    end
    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) begin
        vld_d[k] = vld_q[k-1];
        ret_d[k] = ret_q[k-1];
`ifdef CAST_PIPE_OVF_FLAG_EN
        ovf_d[k] = ovf_q[k-1];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      ret_q <= '0;
`ifdef CAST_PIPE_OVF_FLAG_EN
      ovf_q <= '0;
`endif
    end else begin
      vld_q <= vld_d;
      ret_q <= ret_d;
`ifdef CAST_PIPE_OVF_FLAG_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign io.in_ready  = enable & ~reset & load[0];
  assign io.out_valid = vld_q[STAGES-1];
  assign io.ret       = ret_q[STAGES-1];
`ifdef CAST_PIPE_OVF_FLAG_EN
  assign io.ovf       = ovf_q[STAGES-1];
`endif
endmodule
